// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the KURM ALU: decodes an instruction, reads operands from
// an internal register file and holds a registered operand bundle, stalling on hazards.
module alu_operand_stage #(
    parameter int NREG = 8,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         c_in,
    output logic [2:0]   ALUOp,
    output logic [2:0]   out_rd,
    input  logic         wb_en,
    input  logic [2:0]   wb_addr,
    input  logic [W-1:0] wb_data,
    input  logic         flag_we,
    input  logic         flag_c
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; a producer holds valid and its payload steady until that edge.

    logic [W-1:0]    rf [NREG];
    logic [NREG-1:0] busy;
    logic            carry;
    logic            carry_busy;

    logic [2:0] op;
    logic       imm;
    logic       use_carry;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;

    assign op        = instr[15:13];
    assign imm       = instr[12];
    assign use_carry = instr[11];
    assign rd        = instr[10:8];
    assign rs        = instr[7:5];
    assign rt        = instr[4:2];

    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] rd_set;
    logic [NREG-1:0] busy_eff;
    logic            carry_busy_eff;
    logic            hazard;
    logic            accept;
    logic            sets_carry;
    logic [W-1:0]    rs_val;
    logic [W-1:0]    rt_val;
    logic [W-1:0]    y_val;
    logic            c_val;

    // Writebacks and flag updates returning this cycle release their hazard at once.
    assign wb_clr         = wb_en ? (NREG'(1) << wb_addr) : '0;
    assign rd_set         = (rd != 3'd0) ? (NREG'(1) << rd) : '0;
    assign busy_eff       = busy & ~wb_clr;
    assign carry_busy_eff = carry_busy && !flag_we;

    assign hazard = busy_eff[rs]
                 || (!imm && busy_eff[rt])
                 || ((rd != 3'd0) && busy_eff[rd])
                 || (use_carry && carry_busy_eff);

    assign in_ready   = (!out_valid || out_ready) && !hazard;
    assign accept     = in_valid && in_ready;
    assign sets_carry = (op == 3'b010) || (op == 3'b011);

    always_comb begin
        rs_val = rf[rs];
        if (wb_en && (wb_addr == rs)) rs_val = wb_data;
        if (rs == 3'd0) rs_val = '0;

        rt_val = rf[rt];
        if (wb_en && (wb_addr == rt)) rt_val = wb_data;
        if (rt == 3'd0) rt_val = '0;

        y_val = imm ? {{(W-5){1'b0}}, instr[4:0]} : rt_val;
        c_val = use_carry && (flag_we ? flag_c : carry);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            busy       <= '0;
            carry      <= 1'b0;
            carry_busy <= 1'b0;
        end else begin
            if (wb_en && (wb_addr != 3'd0)) rf[wb_addr] <= wb_data;
            if (flag_we) carry <= flag_c;
            // Set is OR-ed after the clear so a same-cycle set of the same rd wins.
            busy       <= (busy_eff | (accept ? rd_set : '0)) & ~NREG'(1);
            carry_busy <= carry_busy_eff || (accept && sets_carry);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
            c_in      <= 1'b0;
            ALUOp     <= 3'b000;
            out_rd    <= 3'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            x         <= rs_val;
            y         <= y_val;
            c_in      <= c_val;
            ALUOp     <= op;
            out_rd    <= rd;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios then random traffic,
// with a behavioural model feeding an expected-bundle queue and a monitor process.
module tb_alu_operand_stage;

    localparam int W  = 16;
    localparam int BW = 39;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  instr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c_in;
    logic [2:0]   ALUOp;
    logic [2:0]   out_rd;
    logic         wb_en;
    logic [2:0]   wb_addr;
    logic [W-1:0] wb_data;
    logic         flag_we;
    logic         flag_c;

    alu_operand_stage #(.NREG(8), .W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .c_in(c_in), .ALUOp(ALUOp), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_we(flag_we), .flag_c(flag_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0] exp_q[$];

    // behavioural model state
    logic [W-1:0] m_regs [8];
    bit           m_busy [8];
    bit           m_carry;
    bit           m_cb;
    bit           m_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_carry = 0;
        m_cb    = 0;
        m_ov    = 0;
        exp_q.delete();
    endtask

    function automatic logic [W-1:0] model_read(input logic [2:0] a, input bit we,
                                                input logic [2:0] wa, input logic [W-1:0] wd);
        if (a == 3'd0) return '0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    // One clock cycle: drive after the edge, predict and check at the falling edge,
    // then advance the model to the state the next rising edge should produce.
    task automatic step(input bit iv, input logic [15:0] ins, input bit we,
                        input logic [2:0] wa, input logic [W-1:0] wd,
                        input bit fwe, input bit fc, input bit ordy);
        logic [2:0] op, rd, rs, rt;
        bit imm, uc, haz, exp_rdy, acc;
        bit eb [8];
        logic [W-1:0] xv, yv;
        bit cv;
        @(posedge clk);
        #1;
        in_valid  = iv;
        instr     = ins;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        flag_we   = fwe;
        flag_c    = fc;
        out_ready = ordy;
        @(negedge clk);
        op  = ins[15:13];
        imm = ins[12];
        uc  = ins[11];
        rd  = ins[10:8];
        rs  = ins[7:5];
        rt  = ins[4:2];
        for (int i = 0; i < 8; i++) eb[i] = m_busy[i] && !(we && wa == 3'(i));
        haz = eb[rs] || (!imm && eb[rt]) || (rd != 0 && eb[rd]) || (uc && m_cb && !fwe);
        exp_rdy = (!m_ov || ordy) && !haz;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        acc = iv && exp_rdy;
        if (acc) begin
            xv = model_read(rs, we, wa, wd);
            yv = imm ? W'(ins[4:0]) : model_read(rt, we, wa, wd);
            cv = uc && (fwe ? fc : m_carry);
            exp_q.push_back({xv, yv, cv, op, rd});
        end
        if (we) begin
            m_busy[wa] = 0;
            if (wa != 0) m_regs[wa] = wd;
        end
        if (fwe) begin
            m_carry = fc;
            m_cb    = 0;
        end
        if (acc) begin
            if (rd != 0) m_busy[rd] = 1;
            if (op == 3'b010 || op == 3'b011) m_cb = 1;
            m_ov = 1;
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic idle(input bit ordy);
        step(0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, ordy);
    endtask

    task automatic wb(input logic [2:0] a, input logic [W-1:0] d);
        step(0, 16'h0000, 1, a, d, 0, 0, 1);
    endtask

    // scoreboard monitor: the presented bundle must match the oldest expectation,
    // and is retired when the consumer takes it
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL bundle: unexpected x=%h y=%h c=%b op=%b rd=%0d, expected none",
                         x, y, c_in, ALUOp, out_rd);
            end else begin
                if ({x, y, c_in, ALUOp, out_rd} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL bundle: got x=%h y=%h c=%b op=%b rd=%0d expected x=%h y=%h c=%b op=%b rd=%0d",
                             x, y, c_in, ALUOp, out_rd, exp_q[0][38:23], exp_q[0][22:7],
                             exp_q[0][6], exp_q[0][5:3], exp_q[0][2:0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        flag_we   = 1'b0;
        flag_c    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_x", 64'(x), 0);
        chk("reset_y", 64'(y), 0);
        chk("reset_c_in", 64'(c_in), 0);
        chk("reset_aluop", 64'(ALUOp), 0);
        chk("reset_out_rd", 64'(out_rd), 0);
        chk("reset_in_ready", 64'(in_ready), 1);

        // ADD r3,r1,r2 then dependent SUB r4,r3,r1 released by same-cycle writeback
        wb(3'd1, 16'h0005);
        wb(3'd2, 16'h0003);
        step(1, 16'h4328, 0, 3'd0, 16'h0, 0, 0, 0);
        step(1, 16'h6464, 0, 3'd0, 16'h0, 0, 0, 0);
        step(1, 16'h6464, 0, 3'd0, 16'h0, 0, 0, 0);
        step(1, 16'h6464, 0, 3'd0, 16'h0, 0, 0, 1);
        step(1, 16'h6464, 1, 3'd3, 16'h0008, 0, 0, 1);
        // r7 busy, then immediate AND whose rt field names r7
        step(1, 16'h8700, 0, 3'd0, 16'h0, 0, 0, 1);
        step(1, 16'h153F, 0, 3'd0, 16'h0, 0, 0, 1);
        // carry-consuming instruction waits for the flag update
        step(1, 16'h4E28, 0, 3'd0, 16'h0, 0, 0, 1);
        step(1, 16'h4E28, 0, 3'd0, 16'h0, 1, 1, 0);
        // hold the bundle with the consumer stalled
        repeat (3) step(1, 16'h8100, 0, 3'd0, 16'h0, 0, 0, 0);

        // asynchronous reset in the middle of the stall
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        wb_en    = 1'b0;
        flag_we  = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 0);
        chk("midreset_x", 64'(x), 0);
        chk("midreset_out_rd", 64'(out_rd), 0);
        model_reset();
        #1;
        reset_n = 1'b1;
        // r4 was busy before reset; must now issue at once with x=0
        step(1, 16'h8180, 0, 3'd0, 16'h0, 0, 0, 1);
        // r0 writes are discarded
        wb(3'd0, 16'hFFFF);
        step(1, 16'h8100, 0, 3'd0, 16'h0, 0, 0, 1);
        idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit we;
            logic [2:0] wa;
            we = ($urandom_range(0, 9) < 4);
            wa = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (int'(wa) + k) % 8;
                    if (m_busy[j]) begin
                        wa = 3'(j);
                        break;
                    end
                end
            end
            step($urandom_range(0, 9) < 7, 16'($urandom), we, wa, 16'($urandom),
                 $urandom_range(0, 4) == 0, 1'($urandom), $urandom_range(0, 3) != 0);
        end

        // drain with a bounded wait
        for (int n = 0; n < 10 && (m_ov || exp_q.size() != 0); n++) idle(1);
        chk("drain_queue_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Issue stage directly upstream of the 16-bit KURM ALU. Accepts one 16-bit instruction per handshake, reads two operands from an internal 8×16 register file, and presents registered `x`, `y`, `c_in`, `ALUOp` and destination tag to the ALU. It tracks pending register writes and the pending carry flag in a scoreboard, and stalls dependent instructions until writeback and flag update return from downstream.

## Interface
Parameters:
- `NREG`, 8: register count; r0 reads as zero and is never written.
- `W`, 16: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage accepts this cycle; combinational.
- `instr`  in  16  instruction: [15:13] ALUOp, [12] imm, [11] use_carry, [10:8] rd, [7:5] rs, [4:2] rt, [4:0] imm5.
- `out_valid`  out  1  operand bundle valid.
- `out_ready`  in  1  ALU/next stage consumes bundle.
- `x`  out  16  operand A = R[rs].
- `y`  out  16  operand B = R[rt], or zero-extended imm5 when imm=1.
- `c_in`  out  1  carry flag when use_carry=1, else 0.
- `ALUOp`  out  3  passed from instr[15:13].
- `out_rd`  out  3  destination tag.
- `wb_en`, `wb_addr[2:0]`, `wb_data[15:0]`  in  register writeback.
- `flag_we`, `flag_c`  in  carry-flag update (the ALU's c_out).

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = (!out_valid || out_ready) && !hazard`.
- Busy mask B[7:0] (B[0] always 0) and carry_busy bit. Effective mask B' = B with bit `wb_addr` cleared when `wb_en`; effective carry_busy' = carry_busy && !flag_we.
- hazard = B'[rs] || (!imm && B'[rt]) || (rd!=0 && B'[rd]) || (use_carry && carry_busy').
- On accept, register: x, y, c_in, ALUOp, out_rd; out_valid←1. Set B[rd] if rd!=0. Set carry_busy if ALUOp is 010 (ADD) or 011 (SUB).
- Out_valid clears when `out_valid && out_ready` with no new accept in the same cycle; back-to-back accept keeps out_valid at 1.
- Writeback: on `wb_en`, write R[wb_addr]←wb_data unless wb_addr=0; clear B[wb_addr]. A writeback to a non-busy register still writes.
- Same-cycle bypass: a read of rs/rt matching `wb_addr` (nonzero, wb_en) returns wb_data. A use_carry read while flag_we=1 returns flag_c.
- Simultaneous clear and set of the same rd: set wins (B[rd]=1). Same for carry_busy clear and set.
- Carry flag register: on flag_we, carry←flag_c.
- Opcodes 100/101/110 pass through unchanged and do not set carry_busy.

## Timing
- Latency: accepted at edge N, bundle visible after edge N (out_valid=1) and held stable until consumed.
- Throughput: 1 instruction/cycle when there are no hazards and out_ready=1.
- Output bundle is stable while `out_valid && !out_ready`.
- Reset (asserted at any time, including mid-stall): out_valid=0, x=0, y=0, c_in=0, ALUOp=000, out_rd=0, all registers 0, B=0, carry=0, carry_busy=0. in_ready follows from the cleared state, so it is 1 while reset is deasserted with no hazard.

## Test plan
- Reset, then wb R1←0x0005, R2←0x0003; issue ADD r3,r1,r2 (instr 0x4328) -> next cycle x=0x0005, y=0x0003, ALUOp=010, out_rd=3, out_valid=1, B[3]=1.
- With B[3]=1, offer SUB r4,r3,r1 -> in_ready=0 until wb_en to R3 with 0x0008; in that wb cycle accept, and the bundle shows x=0x0008 (bypass).
- AND with imm=1, imm5=0x1F, rs=r1 -> y=0x001F and rt is ignored for hazard.
- ADD sets carry_busy; an ADC-style use_carry instruction stalls; flag_we=1 with flag_c=1 in the same cycle -> accept, c_in=1.
- Hold out_ready=0 with a valid bundle -> in_ready=0 and outputs unchanged for 3 cycles; reset_n pulsed low mid-stall -> out_valid=0 and B=0 immediately (asynchronous).
- wb to r0 with 0xFFFF, then read r0 -> x=0x0000.
